pushsw_debounce: RTL and testbench
==================================

Name: pushsw_debounce

Overview:
- Conditions the four active-low board push switches (gpio21/18/15/14) before they reach the GPIO peripheral input bus (gpio_pin_in).
- Per channel: 2-FF synchronizer, counter-based debounce, press/release edge pulses, sticky press-event latch with write-1-to-clear and a maskable interrupt line.
- Sits between the top-level switch pins and the GPIO block; the core firmware polls debounced levels or services events instead of raw, bouncing pins.

Parameters:
- NUM_SW, 4, number of switch channels.
- DEBOUNCE_CYCLES, 1250000, consecutive stable cycles required to accept a new level (10 ms at 125 MHz); benches override with a small value.
- CNT_W, 21, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- sw_n_in, input, NUM_SW, raw switch pins; low means pressed; asynchronous to clk.
- sw_level, output, NUM_SW, debounced level; 1 means pressed.
- sw_press_pulse, output, NUM_SW, 1-cycle pulse when sw_level rises.
- sw_release_pulse, output, NUM_SW, 1-cycle pulse when sw_level falls.
- irq_en, input, NUM_SW, per-channel interrupt enable.
- evt_clr, input, NUM_SW, write-1-to-clear strobe for evt_pending; valid for one cycle.
- evt_pending, output, NUM_SW, sticky press-event flags.
- evt_irq, output, 1, OR of (evt_pending & irq_en).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Assertion forces every register to its reset value immediately, including mid-count or mid-bounce.
- Reset values:
  - Synchronizer flops: 1 (released).
  - Counters: 0.
  - sw_level, both pulse outputs, evt_pending, evt_irq: 0.
- Synchronizer: sw_n_in passes through 2 flops, then is inverted to form sync_pressed. No logic sits between the two flops.
- Debounce, per channel, 2 states: STABLE and COUNTING.
  - STABLE: if sync_pressed == sw_level, the counter stays 0. On a mismatch, go to COUNTING with count = 1.
  - COUNTING, mismatch persists:
    - If count < DEBOUNCE_CYCLES - 1, increment.
    - If count == DEBOUNCE_CYCLES - 1, toggle sw_level, clear count, return to STABLE.
  - COUNTING, sync_pressed matches sw_level again (bounce): clear count and return to STABLE. sw_level does not change.
  - The counter never wraps; it saturates by construction.
- Latency: a clean pin edge reaches sw_level after exactly 2 + DEBOUNCE_CYCLES clk edges.
- Pulses:
  - sw_press_pulse is high for exactly the one cycle after sw_level goes 0 to 1.
  - sw_release_pulse is high for exactly the one cycle after sw_level goes 1 to 0.
  - Both are registered and never high together on one channel.
- Events:
  - evt_pending[i] sets on sw_press_pulse[i] and clears on evt_clr[i].
  - If set and clear arrive in the same cycle, set wins and the flag stays 1.
  - evt_clr on a flag that is already 0 has no effect.
- evt_irq is combinational from registered evt_pending and irq_en; it follows changes to irq_en in the same cycle.
- Channels are fully independent; simultaneous activity on several channels needs no arbitration.

Decomposition:
- Package rw_gpio_pkg:
  - NUM_PUSH_SW = 4.
  - DEBOUNCE_CYCLES_DEFAULT = 1250000.
  - DEBOUNCE_CNT_W = 21.
  - Localparams for the bit indices of the switches on the GPIO input bus.
- Sub-module debounce_ch: synchronizer, counter and 2-state FSM, producing level, press pulse and release pulse for one channel. It is instantiated NUM_SW times by a generate loop.
- The top level holds the evt_pending latch and the IRQ OR.

Test Plan (DEBOUNCE_CYCLES = 8):
1. Reset, then all pins held 1 -> sw_level = 0, no pulses, evt_pending = 0, evt_irq = 0 for 100 cycles.
2. Clean press: sw_n_in[0] goes 1 to 0 at cycle 0 -> sw_level[0] rises at cycle 10, sw_press_pulse[0] high for cycle 11 only, evt_pending[0] = 1 from cycle 11.
3. Bounce: sw_n_in[1] toggles every 3 cycles for 30 cycles, then holds 0 -> no sw_level change during bouncing; sw_level[1] rises 10 cycles after the final edge; exactly one press pulse.
4. Event/IRQ: evt_pending = 4'b0001.
   - irq_en = 0 -> evt_irq = 0.
   - irq_en = 4'b0001 -> evt_irq = 1.
   - evt_clr = 4'b0001 together with a new press pulse on channel 0 -> evt_pending[0] stays 1.
   - A later lone evt_clr -> evt_pending[0] = 0, evt_irq = 0.
5. Release and simultaneity: channels 2 and 3 are pressed together, then released together -> both sw_level bits rise in the same cycle; release pulses fire in the same cycle; evt_pending is unaffected by the release.
6. Async reset mid-count: assert rst while channel 0 is at count 5 -> all outputs 0 immediately. After deassertion with the pin still 0, a full 10-cycle latency applies again.

Source files
------------

// File: rtl/pushsw_debounce_pkg.sv
// Shared constants for the board push-switch conditioning block and its GPIO hookup.
package rw_gpio_pkg;

    localparam int unsigned NUM_PUSH_SW             = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1250000;
    localparam int unsigned DEBOUNCE_CNT_W          = 21;

    // Bit positions of the conditioned switches on gpio_pin_in
    localparam int unsigned GPIO_BIT_SW0 = 21;
    localparam int unsigned GPIO_BIT_SW1 = 18;
    localparam int unsigned GPIO_BIT_SW2 = 15;
    localparam int unsigned GPIO_BIT_SW3 = 14;

endpackage

// File: rtl/pushsw_debounce_if.sv
// Switch-side and firmware-side signals of the push-switch conditioner.
interface pushsw_debounce_if #(
    parameter int unsigned NUM_SW = rw_gpio_pkg::NUM_PUSH_SW
);
    logic [NUM_SW-1:0] sw_n_in;
    logic [NUM_SW-1:0] sw_level;
    logic [NUM_SW-1:0] sw_press_pulse;
    logic [NUM_SW-1:0] sw_release_pulse;
    logic [NUM_SW-1:0] irq_en;
    logic [NUM_SW-1:0] evt_clr;
    logic [NUM_SW-1:0] evt_pending;
    logic              evt_irq;

    modport master (
        output sw_n_in, irq_en, evt_clr,
        input  sw_level, sw_press_pulse, sw_release_pulse, evt_pending, evt_irq
    );

    modport slave (
        input  sw_n_in, irq_en, evt_clr,
        output sw_level, sw_press_pulse, sw_release_pulse, evt_pending, evt_irq
    );
endinterface

// File: rtl/pushsw_debounce_ch.sv
// One switch channel: 2-FF synchronizer, counter debounce FSM, press/release pulses.
module debounce_ch
    import rw_gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_nxt_c
);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             mismatch_c;

    // Synchronizer idles at 1 (released) so reset never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sw_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign mismatch_c = (~sync2_q) ^ level_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_STABLE: begin
                if (mismatch_c) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_COUNTING: begin
                if (!mismatch_c) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Pulses are one cycle behind the level change
    assign press_d     = level_q & ~level_dly_q;
    assign release_d   = ~level_q & level_dly_q;
    assign press_nxt_c = press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STABLE;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/pushsw_debounce.sv
// Push-switch conditioner: per-channel debounce plus sticky press events and IRQ.
module pushsw_debounce
    import rw_gpio_pkg::*;
#(
    parameter int unsigned NUM_SW          = NUM_PUSH_SW,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    pushsw_debounce_if.slave  bus
);

    logic [NUM_SW-1:0] level_w;
    logic [NUM_SW-1:0] press_w;
    logic [NUM_SW-1:0] release_w;
    logic [NUM_SW-1:0] press_nxt_w;
    logic [NUM_SW-1:0] evt_pending_q, evt_pending_d;

    for (genvar gi = 0; gi < int'(NUM_SW); gi++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .sw_n_i      (bus.sw_n_in[gi]),
            .level_o     (level_w[gi]),
            .press_o     (press_w[gi]),
            .release_o   (release_w[gi]),
            .press_nxt_c (press_nxt_w[gi])
        );
    end

    // Flag rises with the visible press pulse; a set in the pulse cycle still beats a clear
    always_comb begin
        evt_pending_d = (evt_pending_q & ~bus.evt_clr) | press_nxt_w | press_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_pending_q <= '0;
        end else begin
            evt_pending_q <= evt_pending_d;
        end
    end

    assign bus.sw_level         = level_w;
    assign bus.sw_press_pulse   = press_w;
    assign bus.sw_release_pulse = release_w;
    assign bus.evt_pending      = evt_pending_q;
    assign bus.evt_irq          = |(evt_pending_q & bus.irq_en);

endmodule

// File: tb/tb_pushsw_debounce.sv
// Directed bench for pushsw_debounce with a short debounce window.
module tb_pushsw_debounce;
    import rw_gpio_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DC = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pushsw_debounce_if #(.NUM_SW(N)) bus ();

    pushsw_debounce #(
        .NUM_SW          (N),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.sw_n_in = 4'b1111;
        bus.irq_en  = 4'b1111;
        bus.evt_clr = 4'b0000;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq} !== 17'b0)
            $display("FAIL reset_values: got %b required 0", {bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq});
        else pass_cnt++;
        tick(); tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            total_cnt++;
            if ({bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq} !== 17'b0)
                $display("FAIL idle_cycle%0d: got %b required 0", k, {bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq});
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_lvl, exp_prs, exp_evt;
        bus.sw_n_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_lvl = (k >= 10) ? 4'b0001 : 4'b0000;
            exp_prs = (k == 11) ? 4'b0001 : 4'b0000;
            exp_evt = (k >= 11) ? 4'b0001 : 4'b0000;
            total_cnt++;
            if (bus.sw_level !== exp_lvl)
                $display("FAIL clean_level_c%0d: got %b required %b", k, bus.sw_level, exp_lvl);
            else pass_cnt++;
            total_cnt++;
            if (bus.sw_press_pulse !== exp_prs)
                $display("FAIL clean_press_c%0d: got %b required %b", k, bus.sw_press_pulse, exp_prs);
            else pass_cnt++;
            total_cnt++;
            if (bus.evt_pending !== exp_evt)
                $display("FAIL clean_evt_c%0d: got %b required %b", k, bus.evt_pending, exp_evt);
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        int n_press = 0;
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) bus.sw_n_in[1] = ~bus.sw_n_in[1];
            tick();
            if (bus.sw_press_pulse[1]) n_press++;
            total_cnt++;
            if (bus.sw_level[1] !== 1'b0)
                $display("FAIL bounce_level_c%0d: got %b required 0", c, bus.sw_level[1]);
            else pass_cnt++;
        end
        bus.sw_n_in[1] = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (bus.sw_press_pulse[1]) n_press++;
            total_cnt++;
            if (bus.sw_level[1] !== (k >= 10))
                $display("FAIL bounce_settle_c%0d: got %b required %b", k, bus.sw_level[1], (k >= 10));
            else pass_cnt++;
        end
        total_cnt++;
        if (n_press !== 1)
            $display("FAIL bounce_press_count: got %0d required 1", n_press);
        else pass_cnt++;
        bus.evt_clr = 4'b0010;
        tick();
        bus.evt_clr = 4'b0000;
        total_cnt++;
        if (bus.evt_pending !== 4'b0001)
            $display("FAIL bounce_evt_clr: got %b required 0001", bus.evt_pending);
        else pass_cnt++;
    endtask

    task automatic test_evt_irq();
        bus.irq_en = 4'b0000;
        #1;
        total_cnt++;
        if (bus.evt_irq !== 1'b0) $display("FAIL irq_disabled: got %b required 0", bus.evt_irq);
        else pass_cnt++;
        bus.irq_en = 4'b0001;
        #1;
        total_cnt++;
        if (bus.evt_irq !== 1'b1) $display("FAIL irq_enabled: got %b required 1", bus.evt_irq);
        else pass_cnt++;
        bus.irq_en = 4'b0010;
        #1;
        total_cnt++;
        if (bus.evt_irq !== 1'b0) $display("FAIL irq_other_en: got %b required 0", bus.evt_irq);
        else pass_cnt++;
        bus.irq_en = 4'b0001;
        bus.sw_n_in[0] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            total_cnt++;
            if ({bus.sw_level[0], bus.sw_release_pulse[0], bus.evt_pending[0]} !== {(k < 10), (k == 11), 1'b1})
                $display("FAIL release0_c%0d: got %b required %b", k,
                         {bus.sw_level[0], bus.sw_release_pulse[0], bus.evt_pending[0]}, {(k < 10), (k == 11), 1'b1});
            else pass_cnt++;
        end
        bus.sw_n_in[0] = 1'b0;
        repeat (11) tick();
        total_cnt++;
        if (bus.sw_press_pulse[0] !== 1'b1) $display("FAIL repress_pulse: got %b required 1", bus.sw_press_pulse[0]);
        else pass_cnt++;
        bus.evt_clr = 4'b0001;
        tick();
        bus.evt_clr = 4'b0000;
        total_cnt++;
        if ({bus.evt_pending[0], bus.evt_irq} !== 2'b11)
            $display("FAIL set_beats_clr: got %b required 11", {bus.evt_pending[0], bus.evt_irq});
        else pass_cnt++;
        bus.evt_clr = 4'b0001;
        tick();
        bus.evt_clr = 4'b0000;
        total_cnt++;
        if ({bus.evt_pending, bus.evt_irq} !== 5'b00000)
            $display("FAIL lone_clr: got %b required 00000", {bus.evt_pending, bus.evt_irq});
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bus.sw_n_in[3:2] = 2'b00;
        for (int k = 1; k <= 11; k++) begin
            tick();
            total_cnt++;
            if ({bus.sw_level[3:2], bus.sw_press_pulse[3:2]} !== {((k >= 10) ? 2'b11 : 2'b00), ((k == 11) ? 2'b11 : 2'b00)})
                $display("FAIL simul_press_c%0d: got %b required %b", k, {bus.sw_level[3:2], bus.sw_press_pulse[3:2]},
                         {((k >= 10) ? 2'b11 : 2'b00), ((k == 11) ? 2'b11 : 2'b00)});
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.evt_pending !== 4'b1100) $display("FAIL simul_evt: got %b required 1100", bus.evt_pending);
        else pass_cnt++;
        bus.sw_n_in[3:2] = 2'b11;
        for (int k = 1; k <= 11; k++) begin
            tick();
            total_cnt++;
            if ({bus.sw_level[3:2], bus.sw_release_pulse[3:2], bus.evt_pending} !==
                {((k < 10) ? 2'b11 : 2'b00), ((k == 11) ? 2'b11 : 2'b00), 4'b1100})
                $display("FAIL simul_release_c%0d: got %b required %b", k,
                         {bus.sw_level[3:2], bus.sw_release_pulse[3:2], bus.evt_pending},
                         {((k < 10) ? 2'b11 : 2'b00), ((k == 11) ? 2'b11 : 2'b00), 4'b1100});
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_lvl;
        bus.irq_en = 4'b1111;
        bus.sw_n_in[0] = 1'b1;
        repeat (12) tick();
        total_cnt++;
        if ({bus.sw_level, bus.evt_irq} !== 5'b00101)
            $display("FAIL pre_reset_state: got %b required 00101", {bus.sw_level, bus.evt_irq});
        else pass_cnt++;
        bus.sw_n_in[0] = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq} !== 17'b0)
            $display("FAIL async_reset: got %b required 0", {bus.sw_level, bus.sw_press_pulse, bus.sw_release_pulse, bus.evt_pending, bus.evt_irq});
        else pass_cnt++;
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_lvl = (k >= 10) ? 4'b0011 : 4'b0000;
            total_cnt++;
            if (bus.sw_level !== exp_lvl)
                $display("FAIL post_reset_level_c%0d: got %b required %b", k, bus.sw_level, exp_lvl);
            else pass_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_evt_irq();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
